shift_add_multiplier: RTL and testbench
=======================================

// Module: shift_add_multiplier
// PURPOSE
//  Sequential shift-and-add multiplier: inverse datapath of the restoring divider in the
//  same arithmetic unit. Accepts two WIDTH-bit operands on a start pulse, iterates one
//  multiplier bit per clock and returns a 2*WIDTH-bit product with a one-cycle done pulse.
//  Drives the multiply path of the slow/fast arithmetic demonstrator alongside the divider.
// PARAMETERS
//  WIDTH   8   operand width in bits (>=2); product is 2*WIDTH bits
// PORTS
//  clk           in   1         single clock, all state on rising edge
//  rst_n         in   1         asynchronous active-low reset
//  start         in   1         request; sampled only when busy==0
//  multiplicand  in   WIDTH     operand A, captured on accepted start
//  multiplier    in   WIDTH     operand B, captured on accepted start
//  signed_op     in   1         present only with MUL_SIGNED_EN; captured on accepted start
//  busy          out  1         high from cycle after accept until done cycle
//  done          out  1         one-cycle pulse, product valid
//  product       out  2*WIDTH   result; held until next completion
// BEHAVIOUR
//  - One clock, rst_n asserted asynchronously clears: state=IDLE, busy=0, done=0,
//    product=0, count=0, internal acc/operand regs=0. Reset mid-operation aborts with no
//    done pulse; first start after release is accepted normally.
//  - FSM IDLE -> RUN -> FIN -> IDLE.
//    IDLE: busy=0. start=1 at edge T -> load A, B into mq, acc={carry,hi}=0, count=0, RUN.
//    RUN: busy=1. Each edge: if mq[0] then {carry,hi}=hi+A (WIDTH+1 bits, no overflow
//      lost); then {carry,hi,mq} shifted right 1. count++. Iteration at count==WIDTH-1
//      (edge T+WIDTH) moves to FIN.
//    FIN: busy=1. Edge T+WIDTH+1: product<={hi,mq}, done<=1, busy<=0, state IDLE.
//  - Latency: start accepted at edge T -> done high during cycle following edge T+WIDTH+1
//    (WIDTH+2 edges). Throughput one result per WIDTH+2 cycles.
//  - start while busy=1: ignored, operands not re-captured, no queuing.
//  - start high in the same cycle as done: accepted (state already IDLE); done drops next
//    edge, busy rises next edge.
//  - start held high continuously: back-to-back operations, each on an IDLE edge.
//  - Operands may change freely after accept; only captured copies are used.
//  - Zero operands: full WIDTH iterations still run (no early exit); product=0.
//  - Unsigned max: (2^W-1)^2 fits exactly in 2*WIDTH bits; carry bit prevents loss.
//  - done is a pulse, never held >1 cycle; product unchanged except at done edge / reset.
// CONFIGURATION
//  MUL_SIGNED_EN defined: signed_op port exists. signed_op=1 -> operands are two's
//    complement; at load magnitudes are taken, sign = A[W-1]^B[W-1] stored; in FIN the
//    unsigned result is negated if sign=1. Latency unchanged. -2^(W-1) magnitude handled
//    as unsigned 2^(W-1). signed_op=0 -> identical to unsigned build.
//  MUL_SIGNED_EN undefined: no signed_op port, pure unsigned multiply.
// TESTING
//  1. Reset, then start with A=13, B=11 -> done one cycle after edge T+9 (W=8),
//     product=16'd143, busy high exactly 9 cycles.
//  2. A=255, B=255 -> product=16'hFE01; A=0, B=200 -> product=0, same latency.
//  3. Pulse start again at cycles T+2..T+8 with A=7,B=7 -> ignored; product=143 retained.
//  4. start held high, ops (3,5),(100,2) -> products 15 then 200, second done exactly
//     WIDTH+2 cycles after first, no idle gap beyond that.
//  5. Assert rst_n low at T+4 mid-run -> busy/done/product 0 immediately (async); no done;
//     new start (6,9) after release -> product 54.
//  6. MUL_SIGNED_EN, signed_op=1: A=-3 (8'hFD), B=5 -> product=16'hFFF1 (-15);
//     A=-128, B=-1 -> 16'h0080; signed_op=0 with A=8'hFD,B=5 -> 16'h04F1.

Source files
------------

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential shift-and-add multiplier.
// It retires one multiplier bit per clock and returns a 2*WIDTH-bit product
// with a one-cycle done pulse. Latency from an accepted start to done is
// WIDTH+2 clock edges.
// Optional build macro MUL_SIGNED_EN adds the signed_op port. When signed_op
// is high, the operands are treated as two's complement.
module shift_add_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
`ifdef MUL_SIGNED_EN
   input  logic                 signed_op,
`endif
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t             state;
   state_t             next_state;

   logic [WIDTH-1:0]   a_reg;      // captured multiplicand (magnitude in signed mode)
   logic [WIDTH-1:0]   acc_hi;     // upper half of the running product
   logic [WIDTH-1:0]   mq;         // multiplier bits still to retire / low product half
   logic [CNT_W-1:0]   count;
   logic               neg_q;      // final product must be negated

   logic [WIDTH-1:0]   load_a;
   logic [WIDTH-1:0]   load_b;
   logic               load_neg;
   logic [WIDTH:0]     sum;        // carry plus high half after the conditional add
   logic [2*WIDTH-1:0] raw_product;

   // Absolute value of a two's complement operand. The most negative value
   // maps to the unsigned value 2^(WIDTH-1), which is the correct magnitude.
   function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
      logic signed [WIDTH-1:0] neg_v;
      neg_v = -v;
      return v[WIDTH-1] ? $unsigned(neg_v) : $unsigned(v);
   endfunction

   // Apply the stored result sign to the unsigned product.
   function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] p,
                                                     input logic neg);
      return neg ? (~p + (2*WIDTH)'(1)) : p;
   endfunction

`ifdef MUL_SIGNED_EN
   // Select the operand magnitudes and the result sign to capture at start.
   always_comb begin
      load_a   = multiplicand;
      load_b   = multiplier;
      load_neg = 1'b0;
      if (signed_op) begin
         load_a   = magnitude($signed(multiplicand));
         load_b   = magnitude($signed(multiplier));
         load_neg = multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
      end
   end
`else
   // The unsigned build captures the operands unchanged and never negates.
   always_comb begin
      load_a   = multiplicand;
      load_b   = multiplier;
      load_neg = 1'b0;
   end
`endif

   // Conditional add of the multiplicand, one bit wider so that no carry is lost.
   always_comb begin
      sum = {1'b0, acc_hi};
      if (mq[0]) begin
         sum = {1'b0, acc_hi} + {1'b0, a_reg};
      end
      raw_product = {acc_hi, mq};
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: if (start) next_state = S_RUN;
         S_RUN:  if (count == LAST_CNT) next_state = S_FIN;
         S_FIN:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Busy covers the run iterations and the final result cycle.
   always_comb begin
      busy = 1'b0;
      case (state)
         S_RUN:   busy = 1'b1;
         S_FIN:   busy = 1'b1;
         default: busy = 1'b0;
      endcase
   end

   // Datapath: load on accept, shift and add in RUN, publish the result in FIN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg   <= '0;
         acc_hi  <= '0;
         mq      <= '0;
         count   <= '0;
         neg_q   <= 1'b0;
         product <= '0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_reg  <= load_a;
                  mq     <= load_b;
                  acc_hi <= '0;
                  count  <= '0;
                  neg_q  <= load_neg;
               end
            end
            S_RUN: begin
               acc_hi <= sum[WIDTH:1];
               mq     <= {sum[0], mq[WIDTH-1:1]};
               count  <= count + CNT_W'(1);
            end
            S_FIN: begin
               product <= apply_sign(raw_product, neg_q);
               done    <= 1'b1;
            end
            default: begin
               done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Testbench for shift_add_multiplier with WIDTH=8.
// Applies a vector table, hand-written multi-cycle sequences and random
// operations, and compares them against an arithmetic reference model.
module tb_shift_add_multiplier;

   localparam int W = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [W-1:0]     multiplicand = '0;
   logic [W-1:0]     multiplier = '0;
`ifdef MUL_SIGNED_EN
   logic             signed_op = 1'b0;
`endif
   logic             busy;
   logic             done;
   logic [2*W-1:0]   product;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] p;
   } vec_t;

   shift_add_multiplier #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
`ifdef MUL_SIGNED_EN
      .signed_op    (signed_op),
`endif
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer multiply, optionally treating operands as signed.
   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input bit sop);
      longint x, y, r;
      x = sop ? longint'($signed(a)) : longint'(a);
      y = sop ? longint'($signed(b)) : longint'(b);
      r = x * y;
      return r[2*W-1:0];
   endfunction

   // One complete operation: start pulse, latency/busy/product checks, done pulse width.
   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] expected);
      int k;
      int bc;
      logic [2*W-1:0] got;
      @(negedge clk);
      multiplicand = a;
      multiplier   = b;
      start        = 1'b1;
      @(negedge clk);
      start        = 1'b0;
      multiplicand = W'($urandom);
      multiplier   = W'($urandom);
      k  = 0;
      bc = 0;
      while (!done && k < 4*W) begin
         if (busy) bc++;
         @(negedge clk);
         k++;
      end
      check({tag, " latency"}, 64'(k), 64'(W + 1));
      check({tag, " busy cycles"}, 64'(bc), 64'(W + 1));
      check({tag, " busy at done"}, 64'(busy), 64'(0));
      check({tag, " product"}, 64'(product), 64'(expected));
      got = product;
      @(negedge clk);
      check({tag, " done pulse"}, 64'(done), 64'(0));
      check({tag, " product held"}, 64'(product), 64'(got));
   endtask

   initial begin
      vec_t tbl[7];
      vec_t stbl[4];
      int   k;
      int   n;
      int   dk[2];
      logic [2*W-1:0] dp[2];
      bit   saw_done;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      bit   sop;

      tbl[0] = '{a: 8'd13,  b: 8'd11,  p: 16'd143};
      tbl[1] = '{a: 8'd255, b: 8'd255, p: 16'hFE01};
      tbl[2] = '{a: 8'd0,   b: 8'd200, p: 16'd0};
      tbl[3] = '{a: 8'd200, b: 8'd0,   p: 16'd0};
      tbl[4] = '{a: 8'd1,   b: 8'd255, p: 16'd255};
      tbl[5] = '{a: 8'd128, b: 8'd2,   p: 16'd256};
      tbl[6] = '{a: 8'd15,  b: 8'd17,  p: 16'd255};

      stbl[0] = '{a: 8'hFD, b: 8'h05, p: 16'hFFF1};
      stbl[1] = '{a: 8'h80, b: 8'hFF, p: 16'h0080};
      stbl[2] = '{a: 8'h7F, b: 8'h80, p: 16'hC080};
      stbl[3] = '{a: 8'hFD, b: 8'h05, p: 16'h04F1};

      // reset state, checked while rst_n is held low
      #1;
      check("reset busy", 64'(busy), 64'(0));
      check("reset done", 64'(done), 64'(0));
      check("reset product", 64'(product), 64'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // table-driven unsigned vectors
      for (int i = 0; i < 7; i++) begin
         run_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].p);
      end

`ifdef MUL_SIGNED_EN
      for (int i = 0; i < 4; i++) begin
         signed_op = (i < 3);
         run_op($sformatf("stbl%0d", i), stbl[i].a, stbl[i].b, stbl[i].p);
      end
      signed_op = 1'b0;
`endif

      // start pulses while busy must be ignored
      @(negedge clk);
      multiplicand = 8'd13;
      multiplier   = 8'd11;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!done && k < 4*W) begin
         if (k >= 1 && k <= 7) begin
            start        = 1'b1;
            multiplicand = 8'd7;
            multiplier   = 8'd7;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      check("busy-ignore latency", 64'(k), 64'(W + 1));
      check("busy-ignore product", 64'(product), 64'(143));
      repeat (2) @(negedge clk);
      check("busy-ignore no new op", 64'(busy), 64'(0));
      check("busy-ignore product kept", 64'(product), 64'(143));

      // start held high: back-to-back operations
      @(negedge clk);
      multiplicand = 8'd3;
      multiplier   = 8'd5;
      start        = 1'b1;
      @(negedge clk);
      multiplicand = 8'd100;
      multiplier   = 8'd2;
      k  = 0;
      n  = 0;
      dk[0] = 0; dk[1] = 0;
      dp[0] = '0; dp[1] = '0;
      while (n < 2 && k < 6*W) begin
         if (done) begin
            dk[n] = k;
            dp[n] = product;
            n++;
         end
         @(negedge clk);
         k++;
         if (n == 1 && start) begin
            start = 1'b0;
            check("b2b busy after done", 64'(busy), 64'(1));
            check("b2b done pulse", 64'(done), 64'(0));
         end
      end
      start = 1'b0;
      check("b2b done count", 64'(n), 64'(2));
      check("b2b first product", 64'(dp[0]), 64'(15));
      check("b2b second product", 64'(dp[1]), 64'(200));
      check("b2b spacing", 64'(dk[1] - dk[0]), 64'(W + 2));

      // asynchronous reset in the middle of an operation
      @(negedge clk);
      multiplicand = 8'd13;
      multiplier   = 8'd11;
      start        = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async rst busy", 64'(busy), 64'(0));
      check("async rst done", 64'(done), 64'(0));
      check("async rst product", 64'(product), 64'(0));
      saw_done = 1'b0;
      repeat (W + 4) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      check("async rst no done", 64'(saw_done), 64'(0));
      run_op("after reset", 8'd6, 8'd9, 16'd54);

      // randomized operations against the reference model
      for (int i = 0; i < 40; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         if (i % 10 == 0) ra = '0;
         if (i % 10 == 1) rb = '1;
`ifdef MUL_SIGNED_EN
         signed_op = 1'($urandom_range(0, 1));
         sop = signed_op;
`else
         sop = 1'b0;
`endif
         run_op($sformatf("rand%0d", i), ra, rb, ref_mul(ra, rb, sop));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
